// File: rtl/fetch_sequencer.sv
// Program counter owner and single-outstanding instruction fetch sequencer with redirect/kill handling.
// Optional feature macro MISALIGN_TRAP_EN: misaligned redirect targets go to TRAP_VEC and pulse misalign_trap.
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
`ifdef MISALIGN_TRAP_EN
  , parameter logic [31:0] TRAP_VEC = 32'h0000_0100
`endif
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        halt,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        should_branch,
  input  logic        should_jump,
  input  logic [31:0] alu_res,
  input  logic [31:0] branch_offset,
  input  logic [31:0] jump_offset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr_out,
  output logic [31:0] instr_addr_out,
  input  logic        instr_ready,
  output logic        redirect_err,
  output logic        misalign_trap
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_WAIT  = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] fetch_addr_q, fetch_addr_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] instr_addr_q, instr_addr_d;
  logic        kill_q, kill_d;
  logic        valid_q, valid_d;
  logic        err_q, err_d;

  logic               taken;
  logic signed [31:0] off_s;
  logic        [31:0] raw_tgt;
  logic        [31:0] tgt;

  // Jump wins over branch when both flags are set; offsets are two's complement.
  assign taken   = redirect_valid && (should_jump || (should_branch && (alu_res == 32'd0)));
  assign off_s   = should_jump ? jump_offset : branch_offset;
  assign raw_tgt = redirect_pc + off_s;

`ifdef MISALIGN_TRAP_EN
  logic misaligned;
  logic trap_q;

  assign misaligned = (raw_tgt[1:0] != 2'b00);
  assign tgt        = misaligned ? TRAP_VEC : raw_tgt;

  always_ff @(posedge clk) begin
    if (reset) begin
      trap_q <= 1'b0;
    end else begin
      trap_q <= taken && misaligned;
    end
  end

  assign misalign_trap = trap_q;
`else
  assign tgt           = raw_tgt & ~32'h0000_0003;
  assign misalign_trap = 1'b0;
`endif

  assign imem_req       = (state_q == S_FETCH) && !halt && !reset;
  assign imem_addr      = pc_q;
  assign instr_valid    = valid_q;
  assign instr_out      = instr_q;
  assign instr_addr_out = instr_addr_q;
  assign redirect_err   = err_q;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    fetch_addr_d = fetch_addr_q;
    kill_d       = kill_q;
    valid_d      = valid_q;
    instr_d      = instr_q;
    instr_addr_d = instr_addr_q;
    err_d        = err_q | (redirect_valid & should_branch & should_jump);

    case (state_q)
      S_FETCH: begin
        if (imem_req && imem_ready) begin
          fetch_addr_d = pc_q;
          state_d      = S_WAIT;
          kill_d       = taken;
        end
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          // A word whose request predates a redirect is wrong-path and is dropped.
          if (kill_q || taken) begin
            kill_d  = 1'b0;
            state_d = S_FETCH;
          end else begin
            instr_d      = imem_rdata;
            instr_addr_d = fetch_addr_q;
            valid_d      = 1'b1;
            pc_d         = fetch_addr_q + 32'd4;
            state_d      = S_HOLD;
          end
        end else if (taken) begin
          kill_d = 1'b1;
        end
      end
      S_HOLD: begin
        if (taken || instr_ready) begin
          valid_d = 1'b0;
          state_d = S_FETCH;
        end
      end
      default: state_d = S_FETCH;
    endcase

    if (taken) begin
      pc_d = tgt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_FETCH;
      pc_q         <= RESET_PC;
      kill_q       <= 1'b0;
      valid_q      <= 1'b0;
      instr_q      <= 32'd0;
      instr_addr_q <= 32'd0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      kill_q       <= kill_d;
      valid_q      <= valid_d;
      instr_q      <= instr_d;
      instr_addr_q <= instr_addr_d;
      err_q        <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    fetch_addr_q <= fetch_addr_d;
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: transaction-level fetch model, memory responder, decode monitor.
module tb_fetch_sequencer;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] TRAP_VEC = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        reset, halt, redirect_valid, should_branch, should_jump;
  logic [31:0] redirect_pc, alu_res, branch_offset, jump_offset;
  logic        imem_req, imem_ready, imem_rvalid;
  logic [31:0] imem_addr, imem_rdata;
  logic        instr_valid, instr_ready, redirect_err, misalign_trap;
  logic [31:0] instr_out, instr_addr_out;

  fetch_sequencer #(.RESET_PC(RESET_PC)) dut (
    .clk(clk), .reset(reset), .halt(halt),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .should_branch(should_branch), .should_jump(should_jump),
    .alu_res(alu_res), .branch_offset(branch_offset), .jump_offset(jump_offset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr_out(instr_out), .instr_addr_out(instr_addr_out),
    .instr_ready(instr_ready), .redirect_err(redirect_err), .misalign_trap(misalign_trap)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC0DE_5EED;
  endfunction

  // Shared between model, monitor, memory and stimulus
  logic [63:0] sb[$];
  logic [31:0] acc_log[$];
  logic [31:0] hs_addr_log[$];
  int          hs_cyc_log[$];
  int          hs_cnt = 0;
  int          trap_cnt = 0;
  int          cyc = 0;
  logic        mem_new = 1'b0;
  logic [31:0] mem_new_addr = 32'd0;
  bit          mem_rand = 1'b0;
  int          mem_lat_cfg = 0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Reference model: one outstanding fetch, wrong-path words dropped, pc follows the last taken redirect.
  logic [31:0] m_pc, m_addr, raw, tgt;
  logic [63:0] drop;
  logic        m_pend, m_dead, m_held, m_err, m_trap, tk, mis;

  initial forever begin
    @(negedge clk);
    if (reset) begin
      m_pc = RESET_PC; m_pend = 1'b0; m_dead = 1'b0; m_held = 1'b0;
      m_err = 1'b0; m_trap = 1'b0;
      sb.delete();
    end else begin
      chk1("imem_req", imem_req, !halt && !m_pend && !m_held);
      chk32("pc", imem_addr, m_pc);
      chk1("instr_valid", instr_valid, m_held);
      chk1("redirect_err", redirect_err, m_err);
      chk1("misalign_trap", misalign_trap, m_trap);

      tk  = redirect_valid && (should_jump || (should_branch && alu_res == 32'd0));
      raw = redirect_pc + (should_jump ? jump_offset : branch_offset);
`ifdef MISALIGN_TRAP_EN
      mis = (raw % 4) != 0;
      tgt = mis ? TRAP_VEC : raw;
`else
      mis = 1'b0;
      tgt = raw - (raw % 4);
`endif
      m_trap = tk && mis;
      if (redirect_valid && should_branch && should_jump) m_err = 1'b1;

      if (imem_req && imem_ready) begin
        acc_log.push_back(imem_addr);
        m_pend = 1'b1; m_dead = tk; m_addr = imem_addr;
        mem_new = 1'b1; mem_new_addr = imem_addr;
      end else if (m_pend && imem_rvalid) begin
        m_pend = 1'b0;
        if (!m_dead && !tk) begin
          sb.push_back({m_addr, word_of(m_addr)});
          m_held = 1'b1;
          m_pc = m_addr + 32'd4;
        end
      end else if (m_pend && tk) begin
        m_dead = 1'b1;
      end else if (m_held && (instr_ready || tk)) begin
        if (!instr_ready) drop = sb.pop_back();
        m_held = 1'b0;
      end
      if (tk) m_pc = tgt;
    end
  end

  // Decode-side monitor
  logic [63:0] exp_e;
  initial forever begin
    @(negedge clk);
    if (!reset && instr_valid && instr_ready) begin
      if (sb.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL unexpected_instr: got addr %h data %h expected none", instr_addr_out, instr_out);
      end else begin
        exp_e = sb.pop_front();
        chk32("instr_addr_out", instr_addr_out, exp_e[63:32]);
        chk32("instr_out", instr_out, exp_e[31:0]);
      end
      hs_addr_log.push_back(instr_addr_out);
      hs_cyc_log.push_back(cyc);
      hs_cnt++;
    end
    if (misalign_trap === 1'b1) trap_cnt++;
  end

  // Instruction memory responder
  logic        mem_busy = 1'b0;
  int          mem_lat = 0;
  logic [31:0] mem_addr = 32'd0;
  initial begin
    imem_ready = 1'b1; imem_rvalid = 1'b0; imem_rdata = 32'd0;
    forever begin
      @(posedge clk); #1;
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
      if (mem_new) begin
        mem_new  = 1'b0;
        mem_busy = 1'b1;
        mem_addr = mem_new_addr;
        mem_lat  = mem_rand ? int'($urandom_range(0, 3)) : mem_lat_cfg;
      end
      if (mem_busy) begin
        if (mem_lat == 0) begin
          imem_rvalid = 1'b1;
          imem_rdata  = word_of(mem_addr);
          mem_busy    = 1'b0;
        end else begin
          mem_lat--;
        end
      end
      imem_ready = mem_rand ? ($urandom_range(0, 9) < 7) : 1'b1;
    end
  end

  task automatic wait_valid();
    int n = 0;
    while (instr_valid !== 1'b1 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk1("wait_instr_valid", instr_valid, 1'b1);
  endtask

  task automatic get_accept(output logic [31:0] a);
    int n = 0;
    while (acc_log.size() == 0 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    if (acc_log.size() == 0) begin
      n_chk++; n_fail++;
      $display("FAIL accept_timeout: got no request expected one within 40 cycles");
      a = 32'hxxxx_xxxx;
    end else begin
      a = acc_log[0];
    end
  endtask

  task automatic drive_redirect(input logic br, input logic jp, input logic [31:0] rpc,
                                input logic [31:0] alu, input logic [31:0] boff,
                                input logic [31:0] joff);
    redirect_valid = 1'b1; should_branch = br; should_jump = jp;
    redirect_pc = rpc; alu_res = alu; branch_offset = boff; jump_offset = joff;
    @(posedge clk); #1;
    redirect_valid = 1'b0; should_branch = 1'b0; should_jump = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    chk1({tag, "_imem_req"}, imem_req, 1'b0);
    chk32({tag, "_imem_addr"}, imem_addr, RESET_PC);
    chk1({tag, "_instr_valid"}, instr_valid, 1'b0);
    chk32({tag, "_instr_out"}, instr_out, 32'd0);
    chk32({tag, "_instr_addr_out"}, instr_addr_out, 32'd0);
    chk1({tag, "_redirect_err"}, redirect_err, 1'b0);
    chk1({tag, "_misalign_trap"}, misalign_trap, 1'b0);
  endtask

  logic [31:0] a, cap_d, cap_a;
  int          base, h0, t0;

  initial begin
    reset = 1'b1; halt = 1'b0; redirect_valid = 1'b0; should_branch = 1'b0; should_jump = 1'b0;
    redirect_pc = 32'd0; alu_res = 32'd0; branch_offset = 32'd0; jump_offset = 32'd0;
    instr_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("rst");

    // Back-to-back sequential fetch with zero-wait memory
    base = hs_addr_log.size();
    instr_ready = 1'b1; reset = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    chk1("seq_count", hs_addr_log.size() >= base + 3, 1'b1);
    if (hs_addr_log.size() >= base + 3) begin
      for (int i = 0; i < 3; i++) chk32("seq_addr", hs_addr_log[base + i], RESET_PC + 32'(4 * i));
      chk32("seq_gap0", hs_cyc_log[base + 1] - hs_cyc_log[base], 32'd3);
      chk32("seq_gap1", hs_cyc_log[base + 2] - hs_cyc_log[base + 1], 32'd3);
    end

    // Decode stall in HOLD
    instr_ready = 1'b0;
    wait_valid();
    cap_d = instr_out; cap_a = instr_addr_out;
    repeat (5) begin
      @(posedge clk); #1;
      chk1("stall_valid", instr_valid, 1'b1);
      chk32("stall_data", instr_out, cap_d);
      chk32("stall_addr", instr_addr_out, cap_a);
      chk1("stall_req", imem_req, 1'b0);
    end
    instr_ready = 1'b1;

    // Jump resolved while the fetch is waiting on memory
    mem_lat_cfg = 2;
    acc_log.delete();
    get_accept(a);
    h0 = hs_cnt;
    drive_redirect(1'b0, 1'b1, 32'h40, 32'd0, 32'd0, 32'h20);
    acc_log.delete();
    get_accept(a);
    chk32("jump_wait_target", a, 32'h60);
    chk32("jump_wait_drop", hs_cnt, h0);

    // Taken branch in HOLD with same-cycle accept
    mem_lat_cfg = 0;
    instr_ready = 1'b0;
    wait_valid();
    instr_ready = 1'b1;
    acc_log.delete();
    drive_redirect(1'b1, 1'b0, 32'h10, 32'd0, -32'sd8, 32'd0);
    get_accept(a);
    chk32("branch_taken", a, 32'h08);

    // Not-taken branch: sequential fetch continues
    instr_ready = 1'b0;
    wait_valid();
    cap_a = instr_addr_out;
    instr_ready = 1'b1;
    acc_log.delete();
    drive_redirect(1'b1, 1'b0, 32'h10, 32'd5, -32'sd8, 32'd0);
    get_accept(a);
    chk32("branch_not_taken", a, cap_a + 32'd4);

    // Both flags: jump wins, error is sticky
    instr_ready = 1'b0;
    wait_valid();
    instr_ready = 1'b1;
    acc_log.delete();
    drive_redirect(1'b1, 1'b1, 32'h80, 32'd0, 32'h40, 32'h100);
    get_accept(a);
    chk32("both_target", a, 32'h180);
    chk1("both_err", redirect_err, 1'b1);

    // Misaligned jump target
    t0 = trap_cnt;
    instr_ready = 1'b0;
    wait_valid();
    instr_ready = 1'b1;
    acc_log.delete();
    drive_redirect(1'b0, 1'b1, 32'h40, 32'd0, 32'd0, 32'h22);
    get_accept(a);
    repeat (3) @(posedge clk);
    #1;
`ifdef MISALIGN_TRAP_EN
    chk32("misalign_target", a, TRAP_VEC);
    chk32("misalign_pulses", trap_cnt - t0, 32'd1);
`else
    chk32("misalign_target", a, 32'h60);
    chk32("misalign_pulses", trap_cnt - t0, 32'd0);
`endif
    chk1("err_sticky", redirect_err, 1'b1);

    // Reset while a response is still pending; the late response must be ignored
    mem_lat_cfg = 3;
    acc_log.delete();
    get_accept(a);
    reset = 1'b1; halt = 1'b1;
    @(posedge clk); #1;
    check_reset_values("midrst");
    reset = 1'b0;
    h0 = hs_cnt;
    repeat (6) begin
      @(posedge clk); #1;
      chk1("late_rsp_ignored", instr_valid, 1'b0);
    end
    chk32("late_rsp_no_hs", hs_cnt, h0);
    halt = 1'b0;
    acc_log.delete();
    get_accept(a);
    chk32("post_reset_addr", a, RESET_PC);

    // Randomized traffic against the model
    mem_rand = 1'b1;
    repeat (3000) begin
      @(posedge clk); #1;
      halt           = ($urandom_range(0, 9) == 0);
      instr_ready    = ($urandom_range(0, 9) < 6);
      redirect_valid = ($urandom_range(0, 9) == 0);
      should_branch  = ($urandom_range(0, 1) == 1);
      should_jump    = ($urandom_range(0, 2) == 0);
      alu_res        = ($urandom_range(0, 1) == 1) ? 32'd0 : $urandom;
      redirect_pc    = $urandom;
      branch_offset  = 32'($urandom_range(0, 511)) - 32'd256;
      jump_offset    = 32'($urandom_range(0, 4095)) - 32'd2048;
    end
    redirect_valid = 1'b0; should_branch = 1'b0; should_jump = 1'b0;
    halt = 1'b1; instr_ready = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    chk32("drain_empty", sb.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
Owns the program counter and sequences instruction fetch for the core. Issues one request at a time to instruction memory and buffers the returned word toward decode with a valid/ready handshake. Applies branch/jump redirects from execute, replacing the old combinational next-PC mux, and discards wrong-path fetches in flight.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset.
TRAP_VEC, 32'h0000_0100, redirect target for a misaligned branch/jump (optional feature only).

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  synchronous, active-high reset
halt  in  1  suppress new fetch requests while high
redirect_valid  in  1  one-cycle pulse: control instruction resolved in execute
redirect_pc  in  32  address of that control instruction
should_branch  in  1  conditional branch
should_jump  in  1  unconditional jump
alu_res  in  32  branch compare result; zero means taken
branch_offset  in  32  signed branch offset
jump_offset  in  32  signed jump offset
imem_req  out  1  fetch request valid
imem_addr  out  32  fetch address
imem_ready  in  1  memory accepts request this cycle
imem_rvalid  in  1  response valid
imem_rdata  in  32  response instruction word
instr_valid  out  1  buffered instruction valid
instr_out  out  32  buffered instruction
instr_addr_out  out  32  address of instr_out
instr_ready  in  1  decode accepts instruction
redirect_err  out  1  sticky: should_branch and should_jump both seen high with redirect_valid
misalign_trap  out  1  one-cycle pulse, optional feature

Behaviour:
- Reset: pc=RESET_PC, state=FETCH, kill=0, imem_req=0, imem_addr=RESET_PC, instr_valid=0, instr_out=0, instr_addr_out=0, redirect_err=0, misalign_trap=0.
- imem_req is combinational: state==FETCH && !halt && !reset. imem_addr=pc.
- FETCH: on imem_req && imem_ready: fetch_addr<=pc, go WAIT.
- WAIT: on imem_rvalid: if kill, drop the word, clear kill, go FETCH. Otherwise latch instr_out=imem_rdata and instr_addr_out=fetch_addr, set instr_valid, set pc<=fetch_addr+4, go HOLD.
- HOLD: instr_valid=1. On instr_ready, clear instr_valid next cycle and go FETCH.
- Minimum 3 cycles per instruction with zero-wait memory. At most one request outstanding.
- Target decode on redirect_valid, all arithmetic mod 2^32:
  - jump: redirect_pc+jump_offset.
  - branch with alu_res==0: redirect_pc+branch_offset.
  - branch with alu_res!=0, or neither flag set: no redirect, no state change.
  - both flags set: jump wins and redirect_err sets.
- Taken redirect: pc<=target, overriding any pc+4 update in the same cycle.
  - In FETCH with the request accepted the same cycle: go WAIT with kill=1.
  - In FETCH without acceptance: stay in FETCH and issue the new pc next cycle.
  - In WAIT without rvalid: set kill=1.
  - In WAIT with rvalid the same cycle: drop the word, go FETCH.
  - In HOLD: clear instr_valid next cycle and go FETCH. A same-cycle instr_ready still counts as accepted.
- halt: blocks only new requests. An outstanding response completes normally, and HOLD is still drained by instr_ready.
- Reset mid-transaction: returns to reset values. A memory response arriving after reset is ignored (state is FETCH, not WAIT).

Optional Feature:
MISALIGN_TRAP_EN:
- Defined: a taken target with bits[1:0]!=0 sets pc<=TRAP_VEC instead of the target and pulses misalign_trap for one cycle. Kill/flush handling is unchanged.
- Undefined: target bits[1:0] are forced to 00 and misalign_trap is tied 0.

Test Plan:
- Reset, imem_ready=1, 1-cycle response, instr_ready=1 -> imem_addr sequence 0x0,0x4,0x8, one instr_valid every 3 cycles with matching instr_addr_out.
- instr_ready held low 5 cycles in HOLD -> instr_valid stays 1, instr_out stable, imem_req=0 throughout.
- Jump: redirect_pc=0x40, jump_offset=0x20, during WAIT -> response at 0x44 dropped (instr_valid stays 0), next imem_addr=0x60.
- Branch: alu_res=0, redirect_pc=0x10, branch_offset=-8, in HOLD with instr_ready=1 -> next imem_addr=0x08. Same stimulus with alu_res=5 -> no redirect, sequential fetch continues.
- should_branch=should_jump=1, jump_offset=0x100 -> target redirect_pc+0x100, redirect_err=1 and stays 1 until reset.
- MISALIGN_TRAP_EN defined, jump target 0x62 -> imem_addr=0x100, misalign_trap high exactly one cycle. Undefined -> imem_addr=0x60.
